// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-PC generator: BTB counter encodings,
// default vectors and saturating counter helpers.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam int          XLEN_DEF     = 32;
    localparam int          TAG_W_DEF    = 8;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_0004;

    // Entry layout at the default widths; pc_btb rebuilds it from its own parameters.
    typedef struct packed {
        logic                 valid;
        logic [TAG_W_DEF-1:0] tag;
        logic [XLEN_DEF-1:0]  target;
        ctr_t                 ctr;
    } btb_entry_t;

    function automatic ctr_t ctr_inc(input ctr_t c);
        return (c == ST) ? ST : ctr_t'(c + 2'd1);
    endfunction

    function automatic ctr_t ctr_dec(input ctr_t c);
        return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/pc_gen_btb_if.sv
// Fetch-PC generator bus: back-end control/training inputs and IF-stage outputs.
// master drives the controls (back end), slave is the PC generator.
interface pc_gen_btb_if #(
    parameter int XLEN = pc_gen_pkg::XLEN_DEF
) ();
    logic            stall_if_i;
    logic            redirect_valid_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            exception_i;
    logic            upd_valid_i;
    logic [XLEN-1:0] upd_pc_i;
    logic [XLEN-1:0] upd_target_i;
    logic            upd_taken_i;
    logic [XLEN-1:0] pc_if_o;
    logic [XLEN-1:0] pc_plus_4_if_o;
    logic            pred_taken_if_o;
    logic [XLEN-1:0] pred_target_if_o;

    modport master (
        output stall_if_i, redirect_valid_i, redirect_pc_i, exception_i,
        output upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
        input  pc_if_o, pc_plus_4_if_o, pred_taken_if_o, pred_target_if_o
    );

    modport slave (
        input  stall_if_i, redirect_valid_i, redirect_pc_i, exception_i,
        input  upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
        output pc_if_o, pc_plus_4_if_o, pred_taken_if_o, pred_target_if_o
    );
endinterface

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters:
// combinational lookup, training/allocation on upd_valid_i, valid/counter clear on reset.
module pc_btb
    import pc_gen_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int BTB_ENTRIES = 16,
    parameter int TAG_W       = TAG_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] lookup_pc_i,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic [XLEN-1:0] upd_target_i,
    input  logic            upd_taken_i
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        ctr_t             ctr;
    } entry_t;

    entry_t entries_q [BTB_ENTRIES];
    entry_t entries_d [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;
    logic             unused_pc_bits;

    assign lk_idx = lookup_pc_i[IDX_W+1:2];
    assign lk_tag = lookup_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx = upd_pc_i[IDX_W+1:2];
    assign up_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

    // Word-offset and bits above the tag take no part in indexing or matching.
    assign unused_pc_bits = ^{lookup_pc_i, upd_pc_i};

    assign lk_hit = entries_q[lk_idx].valid && (entries_q[lk_idx].tag == lk_tag);
    assign up_hit = entries_q[up_idx].valid && (entries_q[up_idx].tag == up_tag);

    // Lookup reads the registered array only, so a same-cycle update is not bypassed.
    assign pred_taken_o  = lk_hit && entries_q[lk_idx].ctr[1];
    assign pred_target_o = pred_taken_o ? entries_q[lk_idx].target : '0;

    always_comb begin
        entries_d = entries_q;
        if (upd_valid_i) begin
            if (up_hit) begin
                if (upd_taken_i) begin
                    entries_d[up_idx].ctr    = ctr_inc(entries_q[up_idx].ctr);
                    entries_d[up_idx].target = upd_target_i;
                end else begin
                    entries_d[up_idx].ctr    = ctr_dec(entries_q[up_idx].ctr);
                end
            end else if (upd_taken_i) begin
                entries_d[up_idx].valid  = 1'b1;
                entries_d[up_idx].tag    = up_tag;
                entries_d[up_idx].target = upd_target_i;
                entries_d[up_idx].ctr    = WT;
            end
        end
    end

    // Tags and targets are don't-care while invalid, so only valid/ctr are reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                entries_q[i].valid <= 1'b0;
                entries_q[i].ctr   <= WNT;
            end
        end else begin
            entries_q <= entries_d;
        end
    end

endmodule

// File: rtl/pc_gen_btb.sv
// IF-stage fetch-PC generator: PC register, exception/redirect/stall/prediction
// priority mux and BTB. Optional perf counters enabled by defining PC_GEN_PERF_EN.
module pc_gen_btb
    import pc_gen_pkg::*;
#(
    parameter int              XLEN        = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEF),
    parameter logic [XLEN-1:0] EXC_VEC     = XLEN'(EXC_VEC_DEF),
    parameter int              BTB_ENTRIES = 16,
    parameter int              TAG_W       = TAG_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef PC_GEN_PERF_EN
    output logic [31:0] redirect_cnt_o,
    output logic [31:0] btb_hit_cnt_o,
`endif
    pc_gen_btb_if.slave bus
);
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            unused_redirect_bits;

    pc_btb #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES),
        .TAG_W       (TAG_W)
    ) u_btb (
        .clk           (clk),
        .rst_n         (rst_n),
        .lookup_pc_i   (pc_q),
        .pred_taken_o  (pred_taken),
        .pred_target_o (pred_target),
        .upd_valid_i   (bus.upd_valid_i),
        .upd_pc_i      (bus.upd_pc_i),
        .upd_target_i  (bus.upd_target_i),
        .upd_taken_i   (bus.upd_taken_i)
    );

    assign bus.pc_if_o          = pc_q;
    assign bus.pc_plus_4_if_o   = pc_q + XLEN'(4);
    assign bus.pred_taken_if_o  = pred_taken;
    assign bus.pred_target_if_o = pred_target;

    // Redirect targets are forced word-aligned.
    assign unused_redirect_bits = ^bus.redirect_pc_i[1:0];

    always_comb begin
        pc_d = pc_q;
        if (bus.exception_i) begin
            pc_d = EXC_VEC;
        end else if (bus.redirect_valid_i) begin
            pc_d = {bus.redirect_pc_i[XLEN-1:2], 2'b00};
        end else if (bus.stall_if_i) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end else begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef PC_GEN_PERF_EN
    logic [31:0] redirect_cnt_q, redirect_cnt_d;
    logic [31:0] btb_hit_cnt_q, btb_hit_cnt_d;
    logic        backend_redir;

    assign backend_redir = bus.redirect_valid_i || bus.exception_i;

    // A hit only counts when the prediction actually steers fetch.
    always_comb begin
        redirect_cnt_d = redirect_cnt_q + {31'd0, backend_redir};
        btb_hit_cnt_d  = btb_hit_cnt_q
                       + {31'd0, pred_taken && !bus.stall_if_i && !backend_redir};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect_cnt_q <= '0;
            btb_hit_cnt_q  <= '0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            btb_hit_cnt_q  <= btb_hit_cnt_d;
        end
    end

    assign redirect_cnt_o = redirect_cnt_q;
    assign btb_hit_cnt_o  = btb_hit_cnt_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pc_gen_btb.sv
// Directed self-checking bench for pc_gen_btb (default parameters); also checks
// the perf counters when PC_GEN_PERF_EN is defined.
module tb_pc_gen_btb;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
`ifdef PC_GEN_PERF_EN
    logic [31:0] redirect_cnt;
    logic [31:0] btb_hit_cnt;
`endif

    pc_gen_btb_if #(.XLEN(32)) bus ();

    pc_gen_btb #(
        .XLEN        (32),
        .RESET_PC    (32'h0000_0000),
        .EXC_VEC     (32'h0000_0004),
        .BTB_ENTRIES (16),
        .TAG_W       (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef PC_GEN_PERF_EN
        .redirect_cnt_o (redirect_cnt),
        .btb_hit_cnt_o  (btb_hit_cnt),
`endif
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h required 0x%h", tag, obs, exp);
        end
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = pc;
        tick();
        bus.redirect_valid_i = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        bus.upd_valid_i  = 1'b1;
        bus.upd_pc_i     = pc;
        bus.upd_target_i = tgt;
        bus.upd_taken_i  = taken;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.stall_if_i       = 1'b0;
        bus.redirect_valid_i = 1'b0;
        bus.redirect_pc_i    = '0;
        bus.exception_i      = 1'b0;
        bus.upd_valid_i      = 1'b0;
        bus.upd_pc_i         = '0;
        bus.upd_target_i     = '0;
        bus.upd_taken_i      = 1'b0;

        // Reset and sequential fetch
        tick();
        tick();
        chk("rst_pc", bus.pc_if_o, 32'h0);
        chk("rst_pred", {31'd0, bus.pred_taken_if_o}, 32'h0);
        chk("rst_pred_tgt", bus.pred_target_if_o, 32'h0);
        chk("rst_plus4", bus.pc_plus_4_if_o, 32'h4);
`ifdef PC_GEN_PERF_EN
        chk("rst_redir_cnt", redirect_cnt, 32'h0);
        chk("rst_hit_cnt", btb_hit_cnt, 32'h0);
`endif
        rst_n = 1'b1;
        tick();
        chk("seq_4", bus.pc_if_o, 32'h4);
        tick();
        chk("seq_8", bus.pc_if_o, 32'h8);

        // Stall holds, redirect overrides stall, redirect target aligned
        bus.stall_if_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", bus.pc_if_o, 32'h8);
        end
        bus.stall_if_i = 1'b0;
        tick();
        chk("stall_release", bus.pc_if_o, 32'hC);
        bus.stall_if_i = 1'b1;
        redirect_to(32'h100);
        chk("redir_in_stall", bus.pc_if_o, 32'h100);
        redirect_to(32'h103);
        chk("redir_align", bus.pc_if_o, 32'h100);
        bus.stall_if_i = 1'b0;

        // Exception beats redirect
        bus.exception_i = 1'b1;
        redirect_to(32'h200);
        bus.exception_i = 1'b0;
        chk("exc_priority", bus.pc_if_o, 32'h4);

        // BTB train taken, predict, then decay with one not-taken update
        train(32'h20, 32'h80, 1'b1);
        tick();
        bus.upd_valid_i = 1'b0;
        chk("train_pc8", bus.pc_if_o, 32'h8);
        for (int i = 0; i < 6; i++) tick();
        chk("reach_20", bus.pc_if_o, 32'h20);
        chk("pred_20", {31'd0, bus.pred_taken_if_o}, 32'h1);
        chk("pred_tgt_20", bus.pred_target_if_o, 32'h80);
        tick();
        chk("follow_pred", bus.pc_if_o, 32'h80);
        chk("no_pred_tgt0", bus.pred_target_if_o, 32'h0);
        train(32'h20, 32'h0, 1'b0);
        redirect_to(32'h20);
        bus.upd_valid_i = 1'b0;
        chk("decay_pc", bus.pc_if_o, 32'h20);
        chk("decay_pred", {31'd0, bus.pred_taken_if_o}, 32'h0);
        chk("decay_tgt", bus.pred_target_if_o, 32'h0);
        tick();
        chk("decay_next", bus.pc_if_o, 32'h24);

        // No bypass: same-cycle update at the fetched index is not seen
        redirect_to(32'h20);
        train(32'h20, 32'h80, 1'b1);
        chk("nobypass_pred", {31'd0, bus.pred_taken_if_o}, 32'h0);
        tick();
        bus.upd_valid_i = 1'b0;
        chk("nobypass_next", bus.pc_if_o, 32'h24);
        redirect_to(32'h20);
        chk("retrain_pred", {31'd0, bus.pred_taken_if_o}, 32'h1);
        chk("retrain_tgt", bus.pred_target_if_o, 32'h80);

        // Aliasing: 0x60 replaces 0x20 at index 8
        train(32'h60, 32'h90, 1'b1);
        tick();
        bus.upd_valid_i = 1'b0;
        chk("alias_old_pred", bus.pc_if_o, 32'h80);
        redirect_to(32'h20);
        chk("alias_miss", {31'd0, bus.pred_taken_if_o}, 32'h0);
        tick();
        chk("alias_miss_next", bus.pc_if_o, 32'h24);
        redirect_to(32'h60);
        chk("alias_hit", {31'd0, bus.pred_taken_if_o}, 32'h1);
        chk("alias_tgt", bus.pred_target_if_o, 32'h90);
        tick();
        chk("alias_follow", bus.pc_if_o, 32'h90);
`ifdef PC_GEN_PERF_EN
        chk("perf_redir_cnt", redirect_cnt, 32'd8);
        chk("perf_hit_cnt", btb_hit_cnt, 32'd3);
`endif

        // PC wraps modulo 2^32
        redirect_to(32'hFFFF_FFFC);
        chk("wrap_plus4", bus.pc_plus_4_if_o, 32'h0);
        tick();
        chk("wrap_pc", bus.pc_if_o, 32'h0);

        // Mid-run reset overrides a concurrent update and empties the BTB
        rst_n = 1'b0;
        train(32'h20, 32'h80, 1'b1);
        tick();
        rst_n = 1'b1;
        bus.upd_valid_i = 1'b0;
        chk("rst2_pc", bus.pc_if_o, 32'h0);
`ifdef PC_GEN_PERF_EN
        chk("rst2_redir_cnt", redirect_cnt, 32'h0);
        chk("rst2_hit_cnt", btb_hit_cnt, 32'h0);
`endif
        redirect_to(32'h20);
        chk("rst2_pc20", bus.pc_if_o, 32'h20);
        chk("rst2_pred20", {31'd0, bus.pred_taken_if_o}, 32'h0);
        tick();
        chk("rst2_next", bus.pc_if_o, 32'h24);
        redirect_to(32'h60);
        chk("rst2_pred60", {31'd0, bus.pred_taken_if_o}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen_btb.md
Name: pc_gen_btb

Overview:
Parametrised fetch-PC generator for the IF stage, successor to the fixed 32-bit PC mux.
- Adds configurable reset and exception vectors.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so fetch can predict taken branches.
- Back-end redirects (EX/MEM branch resolution, JALR, exception) override prediction.
- The BTB is trained from branch-resolution updates.

Parameters:
XLEN, 32, PC/address width
RESET_PC, 32'h0000_0000, pc_if_o value after reset
EXC_VEC, 32'h0000_0004, target on exception_i
BTB_ENTRIES, 16, number of BTB entries (power of 2, >=2); IDX_W = log2(BTB_ENTRIES)
TAG_W, 8, stored tag bits per entry

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  synchronous, active-low reset
stall_if_i  in  1  hold PC (ignored when a redirect or exception is present)
redirect_valid_i  in  1  back-end redirect (resolved branch/jump/JALR mispredict)
redirect_pc_i  in  XLEN  redirect target
exception_i  in  1  exception/trap; jump to EXC_VEC
upd_valid_i  in  1  BTB training strobe from branch resolution
upd_pc_i  in  XLEN  PC of the resolved branch
upd_target_i  in  XLEN  resolved taken target
upd_taken_i  in  1  resolved direction
pc_if_o  out  XLEN  current fetch PC (registered)
pc_plus_4_if_o  out  XLEN  pc_if_o + 4 (combinational)
pred_taken_if_o  out  1  BTB predicts taken for pc_if_o (combinational)
pred_target_if_o  out  XLEN  predicted target (0 when pred_taken_if_o=0)

Behaviour:
- Reset (rst_n=0 at posedge):
  - pc_if_o <= RESET_PC.
  - All BTB valid bits cleared; counters set to WNT (01).
  - Applies mid-operation and overrides every other input, including upd_valid_i.
- Next-PC priority, evaluated each cycle, first match wins:
  1. exception_i: pc <= EXC_VEC.
  2. redirect_valid_i: pc <= {redirect_pc_i[XLEN-1:2],2'b00}.
  3. stall_if_i: pc holds.
  4. pred_taken_if_o: pc <= pred_target_if_o.
  5. Otherwise: pc <= pc_plus_4_if_o.
- Redirect and exception take effect even while stall_if_i=1.
- Addition wraps modulo 2^XLEN; no overflow flag.
- BTB lookup (combinational, on pc_if_o):
  - idx = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
  - hit = valid[idx] && tag match.
  - pred_taken_if_o = hit && ctr[idx][1].
- BTB update (posedge, when upd_valid_i):
  - Hit, taken: ctr saturating increment (max 11); target <= upd_target_i.
  - Hit, not taken: ctr saturating decrement (min 00); target unchanged.
  - Miss, taken: allocate/replace the entry: valid=1, new tag, target, ctr=WT (10).
  - Miss, not taken: no change.
- Same-cycle lookup and update to the same index: the lookup sees the old contents; the write is visible from the next cycle (no bypass).
- Update concurrent with exception, redirect or stall: the update is still performed.
- Latency:
  - Redirect/exception/prediction: visible on pc_if_o one cycle after the input.
  - BTB training: affects prediction from the cycle after upd_valid_i.

Optional Feature:
Macro PC_GEN_PERF_EN.
- Defined: adds output ports redirect_cnt_o [31:0] and btb_hit_cnt_o [31:0].
  - redirect_cnt_o increments on each cycle with redirect_valid_i or exception_i.
  - btb_hit_cnt_o increments on each non-stalled cycle with pred_taken_if_o=1 and no redirect/exception.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
Shared package (pc_gen_pkg):
- Counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
- BTB entry typedef {valid, tag[TAG_W], target[XLEN], ctr[2]}.
- Default RESET_PC/EXC_VEC constants.

One sub-module, pc_btb:
- Owns the entry array, combinational lookup, update/allocation logic and reset clear.
- Parent pc_gen_btb holds the PC register, the priority mux and the optional perf counters.

Test Plan:
1. Reset and sequential fetch: rst_n=0 for 2 cycles, RESET_PC=0 -> pc_if_o=0, pred_taken_if_o=0; release with no other inputs -> pc 0x0, 0x4, 0x8, 0xC on successive cycles.
2. Stall and redirect: stall_if_i=1 at pc 0x8 for 3 cycles -> pc stays 0x8, then 0xC after release; redirect to 0x100 with stall_if_i=1 -> pc_if_o=0x100 next cycle; redirect_pc_i=0x103 -> pc 0x100.
3. Priority: exception_i=1 and redirect_valid_i=1 (pc 0x200) in the same cycle -> pc_if_o=0x4 (EXC_VEC).
4. BTB train and decay:
   - Update pc 0x20, target 0x80, taken.
   - Fetch reaches 0x20 -> pred_taken_if_o=1, pred_target_if_o=0x80, next pc 0x80.
   - One not-taken update at 0x20 (ctr 10->01) -> pred_taken_if_o=0 at 0x20, next pc 0x24.
5. Aliasing, BTB_ENTRIES=16:
   - Train 0x20->0x80 taken, then 0x60->0x90 taken (both idx 8, tags 0 vs 1).
   - Fetch 0x20 -> miss, next 0x24; fetch 0x60 -> predicts 0x90.
6. Reset mid-run: after training test 4, assert rst_n=0 for 1 cycle together with upd_valid_i=1 -> pc=RESET_PC and the BTB is empty; fetch at 0x20 gives pred_taken_if_o=0. With PC_GEN_PERF_EN defined, both counters read 0.
